// File: rtl/led_strip_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : led_strip_driver
// Description : WS2812-style single-wire serializer. Fetches one LED colour
//               at a time from the colour buffer, shifts it out GRB, MSB
//               first, as PWM-coded bits, and appends a low latch period
//               after each frame. Optional feature macro:
//               LED_STRIP_BRIGHTNESS_EN (saturating left shift of each
//               channel by BRIGHTNESS_SHIFT before latching).
// Revision    : 1.0 - initial release
// ============================================================================
module led_strip_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
    parameter int T0H_CYCLES        = 35,
    parameter int T0L_CYCLES        = 80,
    parameter int T1H_CYCLES        = 70,
    parameter int T1L_CYCLES        = 60,
    parameter int RESET_CYCLES      = 5000,
    parameter int BRIGHTNESS_SHIFT  = 4
) (
    input  logic                         clk_led,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
    output logic                         strand_out,
    output logic                         busy,
    output logic                         frame_done
);

    // State encoding
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LATCH  = 3'd1;
    localparam logic [2:0] c_ST_FETCH  = 3'd2;
    localparam logic [2:0] c_ST_SEND_H = 3'd3;
    localparam logic [2:0] c_ST_SEND_L = 3'd4;

    // Timing counters count down to zero, so each phase loads duration-1
    localparam logic [15:0] c_T0H_LOAD   = 16'(T0H_CYCLES - 1);
    localparam logic [15:0] c_T0L_LOAD   = 16'(T0L_CYCLES - 1);
    localparam logic [15:0] c_T1H_LOAD   = 16'(T1H_CYCLES - 1);
    localparam logic [15:0] c_T1L_LOAD   = 16'(T1L_CYCLES - 1);
    localparam logic [15:0] c_RESET_LOAD = 16'(RESET_CYCLES - 1);

    localparam logic [LED_ADDRESS_WIDTH-1:0] c_LAST_ADDR = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] c_ADDR_ONE  = LED_ADDRESS_WIDTH'(1);

    // Cycles at the start of FETCH during which the buffer's valid is stale
    localparam logic [1:0] c_MASK_LOAD = 2'd2;

`ifdef LED_STRIP_BRIGHTNESS_EN
    localparam int c_BRIGHT_EN = 1;
`else
    localparam int c_BRIGHT_EN = 0;
`endif
    // Effective shift: zero when the feature is off, clamped to the legal 0..4
    localparam int c_SHIFT = c_BRIGHT_EN * ((BRIGHTNESS_SHIFT > 4) ? 4 : BRIGHTNESS_SHIFT);

    // Saturating left shift; identity when c_SHIFT is zero
    function automatic logic [7:0] sat_shl(input logic [7:0] ch);
        logic [15:0] w_wide;
        w_wide = {8'h00, ch} << c_SHIFT;
        return (w_wide[15:8] != 8'h00) ? 8'hFF : w_wide[7:0];
    endfunction

    logic [2:0]                   r_state;
    logic [15:0]                  r_cnt;
    logic [1:0]                   r_mask;
    logic [23:0]                  r_shreg;
    logic [4:0]                   r_bit_cnt;
    logic [LED_ADDRESS_WIDTH-1:0] r_addr;
    logic                         r_frame_sent;
    logic                         r_last_led;
    logic                         r_strand;

    logic [2:0]                   w_next_state;
    logic [15:0]                  w_cnt_next;
    logic [1:0]                   w_mask_next;
    logic [23:0]                  w_shreg_next;
    logic [4:0]                   w_bit_cnt_next;
    logic [LED_ADDRESS_WIDTH-1:0] w_addr_next;
    logic                         w_frame_sent_next;
    logic                         w_last_led_next;
    logic                         w_frame_done;
    logic [23:0]                  w_color;

    assign w_color = {sat_shl(green_in), sat_shl(red_in), sat_shl(blue_in)};

    // Next-state and datapath updates for the serializer FSM
    always_comb begin
        w_next_state      = r_state;
        w_cnt_next        = r_cnt;
        w_mask_next       = r_mask;
        w_shreg_next      = r_shreg;
        w_bit_cnt_next    = r_bit_cnt;
        w_addr_next       = r_addr;
        w_frame_sent_next = r_frame_sent;
        w_last_led_next   = r_last_led;
        w_frame_done      = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    w_next_state      = c_ST_LATCH;
                    w_cnt_next        = c_RESET_LOAD;
                    w_frame_sent_next = 1'b0;
                end
            end

            c_ST_LATCH: begin
                if (r_cnt == 16'd0) begin
                    // Only a latch that follows a transmitted frame reports done
                    w_frame_done      = r_frame_sent;
                    w_frame_sent_next = 1'b0;
                    if (enable) begin
                        w_next_state = c_ST_FETCH;
                        w_mask_next  = c_MASK_LOAD;
                    end else begin
                        w_next_state = c_ST_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            c_ST_FETCH: begin
                if (r_mask != 2'd0) begin
                    w_mask_next = r_mask - 2'd1;
                end else if (color_valid) begin
                    w_shreg_next    = w_color;
                    w_bit_cnt_next  = 5'd23;
                    // Advancing here lets the buffer prefetch the next LED
                    w_addr_next     = (r_addr == c_LAST_ADDR) ? '0 : r_addr + c_ADDR_ONE;
                    w_last_led_next = (r_addr == c_LAST_ADDR);
                    w_next_state    = c_ST_SEND_H;
                    w_cnt_next      = w_color[23] ? c_T1H_LOAD : c_T0H_LOAD;
                end
            end

            c_ST_SEND_H: begin
                if (r_cnt == 16'd0) begin
                    w_next_state = c_ST_SEND_L;
                    w_cnt_next   = r_shreg[23] ? c_T1L_LOAD : c_T0L_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            c_ST_SEND_L: begin
                if (r_cnt == 16'd0) begin
                    if (r_bit_cnt != 5'd0) begin
                        w_shreg_next   = {r_shreg[22:0], 1'b0};
                        w_bit_cnt_next = r_bit_cnt - 5'd1;
                        w_next_state   = c_ST_SEND_H;
                        w_cnt_next     = r_shreg[22] ? c_T1H_LOAD : c_T0H_LOAD;
                    end else if (r_last_led) begin
                        w_frame_sent_next = 1'b1;
                        w_next_state      = c_ST_LATCH;
                        w_cnt_next        = c_RESET_LOAD;
                    end else begin
                        w_next_state = c_ST_FETCH;
                        w_mask_next  = c_MASK_LOAD;
                    end
                end else begin
                    w_cnt_next = r_cnt - 16'd1;
                end
            end

            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; strand is registered from the next state
    always_ff @(posedge clk_led) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 16'd0;
            r_mask       <= 2'd0;
            r_shreg      <= 24'd0;
            r_bit_cnt    <= 5'd0;
            r_addr       <= '0;
            r_frame_sent <= 1'b0;
            r_last_led   <= 1'b0;
            r_strand     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_mask       <= w_mask_next;
            r_shreg      <= w_shreg_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_addr       <= w_addr_next;
            r_frame_sent <= w_frame_sent_next;
            r_last_led   <= w_last_led_next;
            r_strand     <= (w_next_state == c_ST_SEND_H);
        end
    end

    assign next_led_request_address = r_addr;
    assign strand_out               = r_strand;
    assign busy                     = (r_state != c_ST_IDLE);
    assign frame_done               = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_strip_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_led_strip_driver
// Description : Scoreboard bench for led_strip_driver. A colour table indexed
//               by the request address models the buffer; expected words are
//               queued when the table is loaded and a monitor decodes the
//               strand waveform and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_strip_driver;

    localparam int NL    = 3;
    localparam int T0H   = 2;
    localparam int T0L   = 4;
    localparam int T1H   = 4;
    localparam int T1L   = 2;
    localparam int RST_C = 20;

    logic       clk_led = 1'b0;
    logic       rst;
    logic       enable;
    logic       color_valid;
    logic [7:0] green_in;
    logic [7:0] red_in;
    logic [7:0] blue_in;
    logic [1:0] addr;
    logic       strand_out;
    logic       busy;
    logic       frame_done;

    logic [7:0] tab_g [NL];
    logic [7:0] tab_r [NL];
    logic [7:0] tab_b [NL];

    typedef struct {
        logic [23:0] word;
        logic [1:0]  addr;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   fd_count = 0;
    bit   mon_en   = 1'b0;

    always #5 clk_led = ~clk_led;

    assign green_in = (addr < 2'd3) ? tab_g[addr] : 8'h00;
    assign red_in   = (addr < 2'd3) ? tab_r[addr] : 8'h00;
    assign blue_in  = (addr < 2'd3) ? tab_b[addr] : 8'h00;

    led_strip_driver #(
        .NUM_LEDS         (NL),
        .LED_ADDRESS_WIDTH(2),
        .T0H_CYCLES       (T0H),
        .T0L_CYCLES       (T0L),
        .T1H_CYCLES       (T1H),
        .T1L_CYCLES       (T1L),
        .RESET_CYCLES     (RST_C),
        .BRIGHTNESS_SHIFT (4)
    ) dut (
        .clk_led                 (clk_led),
        .rst                     (rst),
        .enable                  (enable),
        .green_in                (green_in),
        .red_in                  (red_in),
        .blue_in                 (blue_in),
        .color_valid             (color_valid),
        .next_led_request_address(addr),
        .strand_out              (strand_out),
        .busy                    (busy),
        .frame_done              (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand model of the channel transform for BRIGHTNESS_SHIFT=4
    function automatic logic [7:0] bright(input logic [7:0] c);
`ifdef LED_STRIP_BRIGHTNESS_EN
        if (c > 8'h0F) return 8'hFF;
        return {c[3:0], 4'h0};
`else
        return c;
`endif
    endfunction

    task automatic set_led(input int i, input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        exp_t e;
        tab_g[i] = g;
        tab_r[i] = r;
        tab_b[i] = b;
        e.word = {bright(g), bright(r), bright(b)};
        e.addr = 2'((i + 1) % NL);
        q.push_back(e);
    endtask

    task automatic monitor();
        logic        prev     = 1'b0;
        logic        lastbit  = 1'b0;
        logic        lastexp  = 1'b0;
        int          hi       = 0;
        int          lo       = 0;
        int          bidx     = 0;
        logic [23:0] word     = '0;
        exp_t        e;
        forever begin
            @(negedge clk_led);
            if (!mon_en) begin
                prev = strand_out;
                bidx = 0;
                continue;
            end
            if (strand_out) begin
                if (!prev) begin
                    if (bidx == 0) begin
                        if (q.size() == 0) check("unexpected_word_start", 1, 0);
                        else check("addr_after_latch", addr, q[0].addr);
                    end else begin
                        check("bit_low_time", lo, lastbit ? T1L : T0L);
                    end
                    hi = 0;
                end
                hi++;
            end else begin
                if (prev) begin
                    check("bit_high_time_legal", (hi == T1H || hi == T0H), 1);
                    lastbit = (hi == T1H);
                    word    = {word[22:0], lastbit};
                    bidx++;
                    lo = 0;
                    if (bidx == 24) begin
                        bidx = 0;
                        if (q.size() == 0) begin
                            check("extra_word", 1, 0);
                        end else begin
                            e = q.pop_front();
                            lastexp = e.word[0];
                            check("word", word, e.word);
                        end
                    end
                end
                lo++;
            end
            prev = strand_out;
            if (frame_done) begin
                fd_count++;
                check("frame_done_gap", lo, (lastexp ? T1L : T0L) + RST_C);
                check("frame_done_addr", addr, 0);
            end
        end
    endtask

    task automatic wait_fd(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_led);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic stim();
        int n;
        bit ok;
        bit bad;
        int fdn;

        repeat (3) @(negedge clk_led);
        check("reset_strand", strand_out, 0);
        check("reset_addr", addr, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk_led);
        check("idle_busy", busy, 0);

        // Frame 1: every LED G=80 R=00 B=01, valid held high
        for (int i = 0; i < NL; i++) set_led(i, 8'h80, 8'h00, 8'h01);
        color_valid = 1'b1;
        mon_en      = 1'b1;
        enable      = 1'b1;
        @(negedge clk_led);
        check("enable_busy", busy, 1);
        check("enable_addr", addr, 0);
        // Latch period plus two masked FETCH cycles plus the accept cycle
        n = 0;
        while (strand_out == 1'b0 && n < 100) begin
            n++;
            @(negedge clk_led);
        end
        check("latch_fetch_low_cycles", n, RST_C + 3);

        wait_fd(2000, ok);
        check("frame1_done_seen", ok, 1);

        // Frame 2: new colours, valid withheld for 30 cycles in FETCH
        color_valid = 1'b0;
        set_led(0, 8'h12, 8'h34, 8'h56);
        set_led(1, 8'hFF, 8'h00, 8'hAA);
        set_led(2, 8'h0F, 8'h10, 8'h03);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk_led);
            if (strand_out || addr != 2'd0 || !busy) bad = 1'b1;
        end
        check("fetch_wait_strand_low", bad, 0);
        color_valid = 1'b1;

        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_led);
            if (addr == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame2_first_accept", ok, 1);
        enable = 1'b0;

        wait_fd(2000, ok);
        check("frame2_done_seen", ok, 1);
        repeat (2) @(negedge clk_led);
        check("end_idle_busy", busy, 0);
        check("end_idle_strand", strand_out, 0);
        check("frame_done_count", fd_count, 2);
        check("queue_drained", q.size(), 0);

        // Reset in the middle of a SEND_H phase
        mon_en = 1'b0;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_led);
            if (strand_out) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_strand_high_seen", ok, 1);
        rst = 1'b1;
        @(negedge clk_led);
        check("abort_strand", strand_out, 0);
        check("abort_addr", addr, 0);
        check("abort_busy", busy, 0);
        rst    = 1'b0;
        enable = 1'b0;
        fdn = 0;
        repeat (40) begin
            @(negedge clk_led);
            if (frame_done) fdn++;
        end
        check("abort_no_frame_done", fdn, 0);
        check("abort_stays_idle", busy, 0);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        color_valid = 1'b0;
        for (int i = 0; i < NL; i++) begin
            tab_g[i] = 8'h00;
            tab_r[i] = 8'h00;
            tab_b[i] = 8'h00;
        end
        fork
            monitor();
            stim();
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
